// File: rtl/qtr_sintable.sv
// Quarter-wave sine/cosine generator with optional phase-accumulator (NCO) front end.
// One lane per output (sin, cos); each lane owns a read port on the quarter table.

module qtr_sintable_lane #(
   parameter int OW    = 8,
   parameter int LGTBL = 6
) (
   input  logic                    i_clk,
   input  logic                    i_reset_n,
   input  logic                    i_ce,
   input  logic [1:0]              i_q,
   input  logic [LGTBL-1:0]        i_idx,
   output logic signed [OW-1:0]    o_val
);
   localparam int DEPTH = 1 << LGTBL;

   // Half-sample offset keeps every entry strictly positive and makes the fold exact.
   function automatic logic [OW-1:0] tbl_entry(input int k);
      real x, term, acc_s;
      x     = 3.14159265358979323846 / 2.0 * (real'(k) + 0.5) / real'(DEPTH);
      term  = x;
      acc_s = x;
      for (int n = 1; n <= 12; n++) begin
         term  = -term * x * x / real'((2 * n) * (2 * n + 1));
         acc_s = acc_s + term;
      end
      return OW'($rtoi(acc_s * real'((1 << (OW - 1)) - 1) + 0.5));
   endfunction

   logic [OW-1:0] rom [DEPTH];

   for (genvar k = 0; k < DEPTH; k++) begin : g_rom
      localparam logic [OW-1:0] VAL = tbl_entry(k);
      assign rom[k] = VAL;
   end

   logic [LGTBL-1:0] addr;
   logic [OW-1:0]    mag_s2;
   logic             neg_s2;

   // Odd quadrants walk the table backwards.
   assign addr = i_q[0] ? ~i_idx : i_idx;

   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         mag_s2 <= '0;
         neg_s2 <= 1'b0;
         o_val  <= '0;
      end else if (i_ce) begin
         mag_s2 <= rom[addr];
         neg_s2 <= i_q[1];
         o_val  <= neg_s2 ? -mag_s2 : mag_s2;
      end
   end
endmodule

module qtr_sintable #(
   parameter int PW    = 8,
   parameter int OW    = 8,
   parameter int LGTBL = 6
) (
   input  logic                 i_clk,
   input  logic                 i_reset_n,
   input  logic                 i_ce,
   input  logic                 i_valid,
   input  logic                 i_mode,
   input  logic                 i_sync,
   input  logic [PW-1:0]        i_phase,
   output logic signed [OW-1:0] o_sin,
   output logic signed [OW-1:0] o_cos,
   output logic                 o_valid
);
   localparam int STAGES = 3;
   localparam int NCH    = 2;

   logic [PW-1:0]             acc;
   logic [PW-1:0]             eff_phase;
   logic [NCH-1:0][1:0]       q_s1;
   logic [LGTBL-1:0]          idx_s1;
   logic [STAGES:1]           vld_pipe;
   logic [NCH-1:0][OW-1:0]    lane_out;

   // Sync forces a phase-zero sample in NCO mode; the accumulator restarts at the step.
   always_comb begin
      eff_phase = i_phase;
      if (i_mode)
         eff_phase = i_sync ? '0 : acc;
   end

   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         acc <= '0;
      end else if (i_ce) begin
         if (i_sync)
            acc <= (i_valid && i_mode) ? i_phase : '0;
         else if (i_valid && i_mode)
            acc <= acc + i_phase;
      end
   end

   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         q_s1     <= '0;
         idx_s1   <= '0;
         vld_pipe <= '0;
      end else if (i_ce) begin
         q_s1[0]  <= eff_phase[PW-1 -: 2];
         q_s1[1]  <= eff_phase[PW-1 -: 2] + 2'd1;
         idx_s1   <= eff_phase[PW-3 -: LGTBL];
         vld_pipe <= {vld_pipe[STAGES-1:1], i_valid};
      end
   end

   if (PW > LGTBL + 2) begin : g_lsb
      logic unused_lsb;
      assign unused_lsb = ^eff_phase[PW-3-LGTBL:0];
   end

   for (genvar ch = 0; ch < NCH; ch++) begin : g_lane
      qtr_sintable_lane #(.OW(OW), .LGTBL(LGTBL)) u_lane (
         .i_clk     (i_clk),
         .i_reset_n (i_reset_n),
         .i_ce      (i_ce),
         .i_q       (q_s1[ch]),
         .i_idx     (idx_s1),
         .o_val     (lane_out[ch])
      );
   end

   assign o_sin   = lane_out[0];
   assign o_cos   = lane_out[1];
   assign o_valid = vld_pipe[STAGES];
endmodule

// File: tb/tb_qtr_sintable.sv
// Randomised scoreboard bench for qtr_sintable: an 8-bit and a 12-bit instance share
// control lines; expectations come from a $sin/$cos model of the truncated phase.

module tb_qtr_sintable;
   localparam real PI = 3.14159265358979323846;

   logic              clk = 1'b0;
   logic              rst_n, ce, valid, mode, sync;
   logic [7:0]        ph8;
   logic [11:0]       ph12;
   logic signed [7:0] s8, c8;
   logic signed [11:0] s12, c12;
   logic              v8, v12;

   always #5 clk = ~clk;

   qtr_sintable #(.PW(8), .OW(8), .LGTBL(6)) u_dut8 (
      .i_clk(clk), .i_reset_n(rst_n), .i_ce(ce), .i_valid(valid), .i_mode(mode),
      .i_sync(sync), .i_phase(ph8), .o_sin(s8), .o_cos(c8), .o_valid(v8));

   qtr_sintable #(.PW(12), .OW(12), .LGTBL(8)) u_dut12 (
      .i_clk(clk), .i_reset_n(rst_n), .i_ce(ce), .i_valid(valid), .i_mode(mode),
      .i_sync(sync), .i_phase(ph12), .o_sin(s12), .o_cos(c12), .o_valid(v12));

   typedef struct {
      int s;
      int c;
      int due;
      int ph;
      bit m0;
   } exp_t;

   exp_t q8[$];
   exp_t q12[$];
   int   en_cnt = 0;
   bit   last_ce = 1'b0;
   int   acc8 = 0, acc12 = 0;
   int   n_tot = 0, n_bad = 0;
   bit   fin_req = 1'b0, fin_ack = 1'b0;
   int   sw_s [256];
   int   sw_c [256];
   bit   sw_seen [256];
   logic [16:0] prev8;
   logic [24:0] prev12;

   function automatic int rnd(input real x);
      return (x >= 0.0) ? $rtoi(x + 0.5) : -$rtoi(0.5 - x);
   endfunction

   // Ideal sine/cosine at the centre of the truncated phase bin.
   function automatic void model(input int p, input int pw, input int ow, input int lg,
                                 output int s, output int c);
      int  pt;
      real ang, a;
      pt  = p >> (pw - 2 - lg);
      ang = 2.0 * PI * (real'(pt) + 0.5) / real'(1 << (lg + 2));
      a   = real'((1 << (ow - 1)) - 1);
      s   = rnd(a * $sin(ang));
      c   = rnd(a * $cos(ang));
   endfunction

   task automatic chk(input string nm, input int act, input int exp);
      n_tot++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // Producer: every accepted sample pushes its expected response.
   always @(posedge clk) begin
      int e8, e12, s, c;
      if (!rst_n) begin
         q8.delete();
         q12.delete();
         acc8    = 0;
         acc12   = 0;
         last_ce = 1'b0;
      end else begin
         last_ce = ce;
         if (ce) begin
            en_cnt++;
            if (valid) begin
               e8  = mode ? (sync ? 0 : acc8)  : int'(ph8);
               e12 = mode ? (sync ? 0 : acc12) : int'(ph12);
               model(e8, 8, 8, 6, s, c);
               q8.push_back('{s: s, c: c, due: en_cnt + 2, ph: e8, m0: !mode});
               model(e12, 12, 12, 8, s, c);
               q12.push_back('{s: s, c: c, due: en_cnt + 2, ph: e12, m0: !mode});
            end
            if (sync) begin
               acc8  = (valid && mode) ? int'(ph8)  : 0;
               acc12 = (valid && mode) ? int'(ph12) : 0;
            end else if (valid && mode) begin
               acc8  = (acc8 + int'(ph8)) % 256;
               acc12 = (acc12 + int'(ph12)) % 4096;
            end
         end
      end
   end

   task automatic mon_dut(input string nm, input int sv, input int cv, input bit vv,
                          inout exp_t q[$], input bit is8);
      bit   ev;
      exp_t e;
      ev = (q.size() > 0) && (q[0].due == en_cnt);
      chk({nm, "_valid"}, int'(vv), int'(ev));
      if (ev) begin
         e = q.pop_front();
         chk({nm, "_sin"}, sv, e.s);
         chk({nm, "_cos"}, cv, e.c);
         if (is8 && e.m0) begin
            sw_s[e.ph]    = sv;
            sw_c[e.ph]    = cv;
            sw_seen[e.ph] = 1'b1;
         end
      end
   endtask

   task automatic final_checks();
      int nseen;
      nseen = 0;
      chk("drain8", q8.size(), 0);
      chk("drain12", q12.size(), 0);
      for (int p = 0; p < 256; p++) if (sw_seen[p]) nseen++;
      chk("sweep_seen", nseen, 256);
      for (int p = 0; p < 256; p++) begin
         chk("sym_half", sw_s[p], -sw_s[(p + 128) % 256]);
         chk("cos_shift", sw_c[p], sw_s[(p + 64) % 256]);
         if (p < 128) chk("sym_mirror", sw_s[p], sw_s[127 - p]);
         chk("range_nz", int'(sw_s[p] != 0 && sw_s[p] <= 127 && sw_s[p] >= -127), 1);
      end
      chk("t0_sin", sw_s[0], 2);
      chk("t0_cos", sw_c[0], 127);
      chk("q1_sin", sw_s[64], 127);
      chk("q1_cos", sw_c[64], -2);
      chk("q3_sin", sw_s[192], -127);
   endtask

   // Monitor: reset zeroing, stall hold, and per-cycle valid/data against the scoreboard.
   always @(negedge clk) begin
      if (!rst_n) begin
         chk("reset_out8", int'({s8, c8, v8}), 0);
         chk("reset_out12", int'({s12, c12, v12}), 0);
      end else if (!last_ce) begin
         chk("stall_hold8", int'({s8, c8, v8}), int'(prev8));
         chk("stall_hold12", int'({s12, c12, v12}), int'(prev12));
      end else begin
         mon_dut("d8", int'(s8), int'(c8), v8, q8, 1'b1);
         mon_dut("d12", int'(s12), int'(c12), v12, q12, 1'b0);
      end
      prev8  = {s8, c8, v8};
      prev12 = {s12, c12, v12};
      if (fin_req && !fin_ack) begin
         final_checks();
         fin_ack = 1'b1;
      end
   end

   task automatic drv(input bit c, input bit v, input bit m, input bit sy,
                      input int p8, input int p12);
      @(posedge clk);
      #1;
      ce    = c;
      valid = v;
      mode  = m;
      sync  = sy;
      ph8   = 8'(p8);
      ph12  = 12'(p12);
   endtask

   initial begin
      rst_n = 1'b0; ce = 1'b1; valid = 1'b0; mode = 1'b0; sync = 1'b0;
      ph8 = '0; ph12 = '0;
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;

      // quadrant points; 12-bit instance also exercises truncated LSBs
      drv(1, 1, 0, 0, 0,   'h400);
      drv(1, 1, 0, 0, 64,  'h401);
      drv(1, 1, 0, 0, 128, 'h403);
      drv(1, 1, 0, 0, 192, 'hC00);
      repeat (5) drv(1, 0, 0, 0, 0, 0);

      // NCO with sync then free-running, wraps after 4 samples
      drv(1, 1, 1, 1, 64, 'h400);
      repeat (5) drv(1, 1, 1, 0, 64, 'h400);
      repeat (5) drv(1, 0, 0, 0, 0, 0);

      // clock-enable stall mid-pipeline
      drv(1, 1, 0, 0, 64, 'h400);
      drv(1, 0, 0, 0, 0, 0);
      repeat (5) drv(0, 0, 0, 0, 0, 0);
      repeat (5) drv(1, 0, 0, 0, 0, 0);

      // asynchronous reset with two samples in flight
      drv(1, 1, 0, 0, 64,  'h100);
      drv(1, 1, 0, 0, 128, 'h200);
      @(posedge clk);
      #2 rst_n = 1'b0;
      valid = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      drv(1, 1, 0, 0, 0, 0);
      repeat (6) drv(1, 0, 0, 0, 0, 0);

      // full mode-0 sweep
      for (int p = 0; p < 256; p++) drv(1, 1, 0, 0, p, p * 16 + int'($urandom_range(0, 15)));
      repeat (4) drv(1, 0, 0, 0, 0, 0);

      // random traffic: stalls, gaps, mode changes, syncs
      repeat (1500) begin
         bit m;
         m = 1'(($urandom % 2));
         drv(($urandom % 6) != 0, 1'($urandom % 2), m, m && (($urandom % 12) == 0),
             int'($urandom % 256), int'($urandom % 4096));
      end
      repeat (8) drv(1, 0, 0, 0, 0, 0);

      fin_req = 1'b1;
      for (int i = 0; i < 20 && !fin_ack; i++) @(posedge clk);
      if (!fin_ack) begin
         $display("FAIL final_ack: got 0 expected 1");
         $fatal(1, "monitor did not complete final checks");
      end
      $display("test done: total=%0d bad=%0d", n_tot, n_bad);
      $finish;
   end
endmodule
